// File: rtl/rv32_icache_pkg.sv
// rv32_icache_pkg: state type and address-field helpers for rv32_icache.
// Define RV32_ICACHE_FLUSH_EN to add the FLUSH state.
package rv32_icache_pkg;

  typedef enum logic [1:0] {
    S_LOOKUP  = 2'd0,
    S_FILL    = 2'd1,
    S_RESPOND = 2'd2
`ifdef RV32_ICACHE_FLUSH_EN
    ,
    S_FLUSH   = 2'd3
`endif
  } state_e;

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int lines);
    return 30 - $clog2(lines);
  endfunction

  // Line index: word address modulo the line count.
  function automatic logic [31:0] addr_index(
    input logic [31:0] a,
    input int          lines
  );
    return (a >> 2) & 32'(lines - 1);
  endfunction

  // Tag: everything above the index field.
  function automatic logic [31:0] addr_tag(
    input logic [31:0] a,
    input int          idxw
  );
    return a >> (2 + idxw);
  endfunction

endpackage

// File: rtl/rv32_icache_ram.sv
// rv32_icache_ram: synchronous tag+data store, one read and one write port.
// A read colliding with a write of the same line returns the written word.
module rv32_icache_ram
  import rv32_icache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int TAGW  = 24
) (
  input  logic                     clk,
  input  logic                     rd_en_in,
  input  logic [$clog2(LINES)-1:0] rd_idx_in,
  output logic [TAGW-1:0]          rd_tag_out,
  output logic [31:0]              rd_data_out,
  input  logic                     wr_en_in,
  input  logic [$clog2(LINES)-1:0] wr_idx_in,
  input  logic [TAGW-1:0]          wr_tag_in,
  input  logic [31:0]              wr_data_in
);

  logic [TAGW+31:0] mem_q [LINES];
  logic [TAGW+31:0] rd_q;
  logic [TAGW+31:0] rd_d;

  // Read data: hold unless read; write-first on an index collision.
  always_comb begin
    rd_d = rd_q;
    if (rd_en_in) begin
      if (wr_en_in && (wr_idx_in == rd_idx_in)) begin
        rd_d = {wr_tag_in, wr_data_in};
      end else begin
        rd_d = mem_q[rd_idx_in];
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en_in) begin
      mem_q[wr_idx_in] <= {wr_tag_in, wr_data_in};
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rd_q <= rd_d;
  end

  assign rd_tag_out  = rd_q[TAGW+31:32];
  assign rd_data_out = rd_q[31:0];

endmodule

// File: rtl/rv32_icache.sv
// rv32_icache: direct-mapped one-word-line instruction cache for fetch.
// Define RV32_ICACHE_FLUSH_EN to add flush_in and the FLUSH state.
module rv32_icache
  import rv32_icache_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_read_in,
  input  logic [31:0] instr_address_in,
`ifdef RV32_ICACHE_FLUSH_EN
  input  logic        flush_in,
`endif
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  output logic        mem_read_out,
  output logic [31:0] mem_address_out,
  input  logic [31:0] mem_read_value_in,
  input  logic        mem_ready_in
);

  localparam int IDX  = idx_bits(LINES);
  localparam int TAGW = tag_bits(LINES);

  state_e           state_q, state_d;
  logic [29:0]      req_word_q, req_word_d;
  logic             cap_q, cap_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [LINES-1:0] valid_q, valid_d;
`ifdef RV32_ICACHE_FLUSH_EN
  logic [IDX-1:0]   fidx_q, fidx_d;
  logic             fpend_q, fpend_d;
`endif

  logic [31:0]     req_addr;
  logic [IDX-1:0]  req_idx;
  logic [IDX-1:0]  in_idx;
  logic [TAGW-1:0] req_tag;
  logic [TAGW-1:0] ram_tag;
  logic [31:0]     ram_data;
  logic            rd_en;
  logic            wr_en;
  logic            hit;
  logic            miss;
  logic            unused_bits;

  assign req_addr    = {req_word_q, 2'b00};
  assign req_idx     = IDX'(addr_index(req_addr, LINES));
  assign req_tag     = TAGW'(addr_tag(req_addr, IDX));
  assign in_idx      = IDX'(addr_index(instr_address_in, LINES));
  assign unused_bits = ^instr_address_in[1:0];

  // Lookup result for the address captured on the previous edge.
  assign hit  = cap_q && (state_q == S_LOOKUP) &&
                valid_q[req_idx] && (ram_tag == req_tag);
  assign miss = cap_q && (state_q == S_LOOKUP) && !hit;

  rv32_icache_ram #(
    .LINES (LINES),
    .TAGW  (TAGW)
  ) u_ram (
    .clk         (clk),
    .rd_en_in    (rd_en),
    .rd_idx_in   (in_idx),
    .rd_tag_out  (ram_tag),
    .rd_data_out (ram_data),
    .wr_en_in    (wr_en),
    .wr_idx_in   (req_idx),
    .wr_tag_in   (req_tag),
    .wr_data_in  (mem_read_value_in)
  );

  // Next-state: capture, miss detection, fill and flush sequencing.
  always_comb begin
    state_d    = state_q;
    req_word_d = req_word_q;
    cap_d      = 1'b0;
    rdata_d    = rdata_q;
    valid_d    = valid_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
`ifdef RV32_ICACHE_FLUSH_EN
    fidx_d     = fidx_q;
    fpend_d    = fpend_q;
`endif
    unique case (state_q)
      S_LOOKUP, S_RESPOND: begin
        state_d = S_LOOKUP;
`ifdef RV32_ICACHE_FLUSH_EN
        if (flush_in) begin
          state_d = S_FLUSH;
          fidx_d  = '0;
        end else
`endif
        if (miss) begin
          state_d = S_FILL;
        end else if (instr_read_in) begin
          req_word_d = instr_address_in[31:2];
          cap_d      = 1'b1;
          rd_en      = 1'b1;
        end
      end
      S_FILL: begin
`ifdef RV32_ICACHE_FLUSH_EN
        if (flush_in) begin
          fpend_d = 1'b1;
        end
`endif
        if (mem_ready_in) begin
          wr_en            = 1'b1;
          valid_d[req_idx] = 1'b1;
          rdata_d          = mem_read_value_in;
          state_d          = S_RESPOND;
`ifdef RV32_ICACHE_FLUSH_EN
          if (flush_in || fpend_q) begin
            state_d = S_FLUSH;
            fidx_d  = '0;
            fpend_d = 1'b0;
          end
`endif
        end
      end
`ifdef RV32_ICACHE_FLUSH_EN
      S_FLUSH: begin
        valid_d[fidx_q] = 1'b0;
        fidx_d          = fidx_q + 1'b1;
        if (fidx_q == IDX'(LINES - 1)) begin
          state_d = S_LOOKUP;
        end
      end
`endif
      default: begin
        state_d = S_LOOKUP;
      end
    endcase
  end

  // State and request registers; reset drops any outstanding fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOOKUP;
      req_word_q <= '0;
      cap_q      <= 1'b0;
      rdata_q    <= '0;
      valid_q    <= '0;
`ifdef RV32_ICACHE_FLUSH_EN
      fidx_q     <= '0;
      fpend_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_word_q <= req_word_d;
      cap_q      <= cap_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
`ifdef RV32_ICACHE_FLUSH_EN
      fidx_q     <= fidx_d;
      fpend_q    <= fpend_d;
`endif
    end
  end

  assign mem_read_out    = (state_q == S_FILL);
  assign mem_address_out = {req_word_q, 2'b00};
  assign instr_ready_out = hit || (state_q == S_RESPOND);

  // Returned word: filled word in RESPOND, RAM word on a hit.
  always_comb begin
    instr_read_value_out = '0;
    if (state_q == S_RESPOND) begin
      instr_read_value_out = rdata_q;
    end else if (hit) begin
      instr_read_value_out = ram_data;
    end
  end

endmodule
